student_fir_requant_fifo: RTL
=============================

Name: student_fir_requant_fifo

Overview:
- Downstream of the parallel FIR adder tree. Consumes the 32-bit accumulated output and its one-cycle valid strobe.
- Requantizes each result to a 16-bit audio sample: arithmetic right shift, round-half-up, saturate.
- Buffers results in a small FIFO behind a valid/ready interface, so the audio output stage (I2S/DAC side) can pull samples at its own pace.

Parameters:
- DATA_SIZE_FIR_OUT, 32, width of the incoming FIR sum (signed, two's complement).
- DATA_SIZE, 16, width of the output sample (signed).
- FIFO_DEPTH, 8, number of sample entries; power of two, >= 2.
- SAT_CNT_WIDTH, 16, width of the saturation event counter.

Ports:
- clk_i, input, 1, system clock.
- rst_ni, input, 1, reset, asynchronous, active-low.
- valid_strobe_in, input, 1, single-cycle strobe; y_in is valid this cycle.
- y_in, input, DATA_SIZE_FIR_OUT, signed FIR sum.
- shift_i, input, 5, right-shift amount (0..31); sampled together with valid_strobe_in.
- clear_i, input, 1, synchronous flush of FIFO, pipeline and status.
- sample_out, output, DATA_SIZE, head-of-FIFO sample.
- sample_valid_o, output, 1, FIFO non-empty.
- sample_ready_i, input, 1, consumer accepts sample_out when sample_valid_o is also 1.
- fifo_level_o, output, $clog2(FIFO_DEPTH)+1, current occupancy.
- overflow_o, output, 1, sticky: a sample was dropped because the FIFO was full.
- sat_count_o, output, SAT_CNT_WIDTH, number of saturated samples; saturates at all-ones.

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs are 0: sample_out, sample_valid_o, fifo_level_o, overflow_o, sat_count_o.
  - Pointers and pipeline valid bits are cleared.
  - Reset asserted mid-operation discards all buffered and in-flight samples immediately.
- Stage 1 (register, enabled on valid_strobe_in):
  - Extend y_in to DATA_SIZE_FIR_OUT+1 bits signed.
  - Add 2^(shift_i-1) if shift_i>0, else add 0.
  - Arithmetic right shift by shift_i.
  - The extra bit prevents rounding overflow, e.g. 0x7FFFFFFF at shift 1.
- Stage 2 (register):
  - Saturate to a signed DATA_SIZE-bit value: above 32767 gives 0x7FFF; below -32768 gives 0x8000.
  - Flag a saturation event.
  - Write the result into the FIFO at the end of this cycle.
- Latency:
  - Strobe at cycle N produces a FIFO write at the end of cycle N+1.
  - If the FIFO was empty, sample_valid_o=1 from cycle N+2.
  - Back-to-back strobes every cycle are supported (throughput 1/clk).
- FIFO:
  - First-word-fall-through: sample_out = mem[rd_ptr], combinational from registered state.
  - sample_valid_o = (level != 0).
  - Pop occurs when sample_valid_o && sample_ready_i.
  - sample_ready_i while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Full handling:
  - Write while full without a same-cycle pop: the new sample is dropped, overflow_o is set, and FIFO contents are unchanged.
  - Write while full with a same-cycle pop: both occur, level stays FIFO_DEPTH, no overflow.
- Write and pop in the same cycle while non-empty: level is unchanged.
- Saturation counter: increments on each saturated sample that is written or dropped; holds at its maximum value.
- clear_i=1 (synchronous, priority over everything except reset):
  - Empties the FIFO and kills stage 1/2 valid bits.
  - Zeroes overflow_o and sat_count_o.
  - A strobe arriving in the same cycle is discarded.

Optional Feature:
- Macro: STUDENT_FIR_REQUANT_SAT_CNT_EN.
- Defined: the saturation counter is implemented as described.
- Undefined: no counter register; sat_count_o is tied to 0. Saturation itself still applies.

Test Plan:
- shift_i=15, y_in=0x00004000 (16384), ready=1 -> sample_out=0x0001, sample_valid_o high exactly 2 cycles after strobe; y_in=0x00003FFF -> 0x0000.
- shift_i=0: y_in=0x00010000 -> 0x7FFF; y_in=0xFFFF0000 -> 0x8000; y_in=0x7FFFFFFF -> 0x7FFF; sat_count_o=3. With the macro undefined, sat_count_o stays 0.
- shift_i=8: y_in=0xFFFFFF80 (-128) -> 0x0000; y_in=0xFFFFFF7F (-129) -> 0xFFFF; y_in=0x00000180 -> 0x0002.
- Ready held 0, 9 consecutive strobes with shift 0 and y=1..9 -> level=8, overflow_o=1; draining yields 1..8 in order, then valid=0 and level=0; clear_i -> overflow_o=0.
- FIFO full (level 8), ready=1 in the same cycle as a strobe -> level stays 8, overflow_o stays 0, pop order preserved.
- With 5 entries buffered and one strobe in flight, pulse rst_ni low for 1 cycle (asynchronous) -> outputs go to 0 before the next edge; after release, no stale sample appears.

Source files
------------

// File: rtl/student_fir_requant_fifo.sv
// Requantizes signed FIR sums to DATA_SIZE audio samples (round-half-up, saturate) into a FWFT FIFO.
// Define STUDENT_FIR_REQUANT_SAT_CNT_EN to build the saturation event counter behind sat_count_o.
module student_fir_requant_fifo #(
  parameter int DATA_SIZE_FIR_OUT = 32,
  parameter int DATA_SIZE         = 16,
  parameter int FIFO_DEPTH        = 8,
  parameter int SAT_CNT_WIDTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           valid_strobe_in,
  input  logic [DATA_SIZE_FIR_OUT-1:0]   y_in,
  input  logic [4:0]                     shift_i,
  input  logic                           clear_i,
  output logic [DATA_SIZE-1:0]           sample_out,
  output logic                           sample_valid_o,
  input  logic                           sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o,
  output logic                           overflow_o,
  output logic [SAT_CNT_WIDTH-1:0]       sat_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = DATA_SIZE_FIR_OUT + 1;
  localparam int UW = XW - DATA_SIZE + 1;
  localparam logic [AW-1:0]        PTR_ONE    = AW'(1'b1);
  localparam logic [AW:0]          LVL_ONE    = (AW + 1)'(1'b1);
  localparam logic [AW:0]          LVL_FULL   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [XW-1:0]        RND_ONE    = XW'(1'b1);
  localparam logic [DATA_SIZE-1:0] SAMPLE_MAX = {1'b0, {(DATA_SIZE - 1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SAMPLE_MIN = {1'b1, {(DATA_SIZE - 1){1'b0}}};

  logic signed [XW-1:0]  w_ext;
  logic signed [XW-1:0]  w_rnd;
  logic signed [XW-1:0]  w_shifted;
  logic signed [XW-1:0]  r_s1_val;
  logic                  r_s1_valid;
  logic [UW-1:0]         w_upper;
  logic                  w_sat;
  logic [DATA_SIZE-1:0]  w_sat_val;

  logic [DATA_SIZE-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_level;
  logic                  r_overflow;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  // Stage-1 arithmetic: one guard bit so adding the rounding constant cannot wrap
  always_comb begin
    w_ext = $signed({y_in[DATA_SIZE_FIR_OUT-1], y_in});
    if (shift_i != 5'd0) begin
      w_rnd = $signed(RND_ONE << (shift_i - 5'd1));
    end else begin
      w_rnd = '0;
    end
    w_shifted = (w_ext + w_rnd) >>> shift_i;
  end

  // Stage-1 register, loaded on each strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= '0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0;
      r_s1_val   <= r_s1_val;
    end else begin
      r_s1_valid <= valid_strobe_in;
      if (valid_strobe_in) begin
        r_s1_val <= w_shifted;
      end else begin
        r_s1_val <= r_s1_val;
      end
    end
  end

  // Stage-2 saturation: value fits when all bits above the output sign bit agree
  always_comb begin
    w_upper = r_s1_val[XW-1:DATA_SIZE-1];
    w_sat   = !((&w_upper) || !(|w_upper));
    if (!w_sat) begin
      w_sat_val = r_s1_val[DATA_SIZE-1:0];
    end else if (r_s1_val[XW-1]) begin
      w_sat_val = SAMPLE_MIN;
    end else begin
      w_sat_val = SAMPLE_MAX;
    end
  end

  // FIFO handshake decode; a full FIFO still accepts a write when the head leaves this cycle
  always_comb begin
    w_full = (r_level == LVL_FULL);
    w_pop  = (r_level != '0) && sample_ready_i;
    w_push = r_s1_valid && (!w_full || w_pop);
    w_drop = r_s1_valid && w_full && !w_pop;
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sat_val;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign sample_out     = r_mem[r_rd_ptr];
  assign sample_valid_o = (r_level != '0);
  assign fifo_level_o   = r_level;
  assign overflow_o     = r_overflow;

`ifdef STUDENT_FIR_REQUANT_SAT_CNT_EN
  localparam logic [SAT_CNT_WIDTH-1:0] SAT_ONE = SAT_CNT_WIDTH'(1'b1);
  logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

  // Saturation events count whether the sample was stored or dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sat_cnt <= '0;
    end else if (clear_i) begin
      r_sat_cnt <= '0;
    end else if (r_s1_valid && w_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + SAT_ONE;
    end else begin
      r_sat_cnt <= r_sat_cnt;
    end
  end

  assign sat_count_o = r_sat_cnt;
`else
  assign sat_count_o = '0;
`endif

endmodule
